// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan controller: active-low glyphs {g..a}
// and the supported digit-count ceiling.
package sseg_pkg;

  localparam int MAX_DIGITS = 16;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational nibble-to-glyph decoder; letters A-F appear only in hex mode,
// otherwise those codes render blank.
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] pattern
);

  // Glyph lookup
  always_comb begin
    pattern = SEG_BLANK;
    case (nibble)
      4'h0:    pattern = SEG_0;
      4'h1:    pattern = SEG_1;
      4'h2:    pattern = SEG_2;
      4'h3:    pattern = SEG_3;
      4'h4:    pattern = SEG_4;
      4'h5:    pattern = SEG_5;
      4'h6:    pattern = SEG_6;
      4'h7:    pattern = SEG_7;
      4'h8:    pattern = SEG_8;
      4'h9:    pattern = SEG_9;
      4'hA:    pattern = hex_mode ? SEG_A : SEG_BLANK;
      4'hB:    pattern = hex_mode ? SEG_B : SEG_BLANK;
      4'hC:    pattern = hex_mode ? SEG_C : SEG_BLANK;
      4'hD:    pattern = hex_mode ? SEG_D : SEG_BLANK;
      4'hE:    pattern = hex_mode ? SEG_E : SEG_BLANK;
      4'hF:    pattern = hex_mode ? SEG_F : SEG_BLANK;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous shadowing,
// guard interval and PWM dimming. Define SSEG_LZB_EN for leading-zero blanking.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int GUARD      = 2,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    scan_en,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    hex_mode,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(SCAN_DIV - 1);
  localparam logic [PCNT_W-1:0] PCNT_GUARD = PCNT_W'(GUARD);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [PCNT_W-1:0]       pcnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [BRIGHT_W-1:0]     pwm_r;
  logic [4*NUM_DIGITS-1:0] sh_data_r;
  logic [NUM_DIGITS-1:0]   sh_dp_r;
  logic [NUM_DIGITS-1:0]   sh_en_r;
  logic                    load_pending_r;
  logic                    boundary_r;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic                    frame_done_r;

  logic                    slot_end_s;
  logic                    wrap_s;
  logic [3:0]              nib_s;
  logic [6:0]              glyph_s;
  logic [NUM_DIGITS-1:0]   lzb_s;
  logic                    pwm_on_s;
  logic                    lit_s;
  logic [NUM_DIGITS-1:0]   onehot_s;

  assign slot_end_s = scan_en && (pcnt_r == PCNT_LAST);
  assign wrap_s     = slot_end_s && (idx_r == IDX_LAST);

  // Prescaler, digit index, free-running PWM counter and frame marker
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_r     <= '0;
      idx_r      <= '0;
      pwm_r      <= '0;
      boundary_r <= 1'b0;
    end else begin
      if (slot_end_s) begin
        pcnt_r <= '0;
        idx_r  <= wrap_s ? '0 : idx_r + IDX_W'(1);
      end else if (scan_en) begin
        pcnt_r <= pcnt_r + PCNT_W'(1);
      end else begin
        pcnt_r <= pcnt_r;
      end
      pwm_r      <= pwm_r + BRIGHT_W'(1);
      boundary_r <= wrap_s;
    end
  end

  // Shadow capture at frame wrap, plus one capture right after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_data_r      <= '0;
      sh_dp_r        <= '0;
      sh_en_r        <= '0;
      load_pending_r <= 1'b1;
    end else begin
      if (load_pending_r || wrap_s) begin
        sh_data_r <= data;
        sh_dp_r   <= dp_in;
        sh_en_r   <= digit_en;
      end
      load_pending_r <= 1'b0;
    end
  end

`ifdef SSEG_LZB_EN
  // Leading-zero blanking: scan from the top digit while nibbles stay zero and no dp
  always_comb begin : lzb_scan
    logic run_v;
    lzb_s = '0;
    run_v = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_v = run_v & (sh_data_r[4*i +: 4] == 4'h0) & ~sh_dp_r[i];
      if (i > 0) begin
        lzb_s[i] = run_v;
      end else begin
        lzb_s[i] = 1'b0;
      end
    end
  end
`else
  assign lzb_s = '0;
`endif

  assign nib_s    = sh_data_r[{idx_r, 2'b00} +: 4];
  assign pwm_on_s = (&bright) || (pwm_r < bright);
  assign lit_s    = sh_en_r[idx_r] & ~lzb_s[idx_r] & (pcnt_r >= PCNT_GUARD) & pwm_on_s;
  assign onehot_s = NUM_DIGITS'(1) << idx_r;

  sseg_hex_decoder u_dec (
    .nibble   (nib_s),
    .hex_mode (hex_mode),
    .pattern  (glyph_s)
  );

  // Registered pin drive; dark slots also blank cathodes to avoid ghosting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_r         <= '1;
      seg_r        <= SEG_BLANK;
      dp_r         <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= lit_s ? ~onehot_s : '1;
      seg_r        <= lit_s ? glyph_s : SEG_BLANK;
      dp_r         <= lit_s ? ~sh_dp_r[idx_r] : 1'b1;
      frame_done_r <= boundary_r;
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign frame_done = frame_done_r;

endmodule
